// File: rtl/meduram_pkg.sv
// Shared definitions for the multi-port RAM (meduram) blocks: bank-index
// width helper and the default bank-index type.
package meduram_pkg;

  // Width of one bank index; never narrower than one bit so that a
  // single-bank build still has a legal select bus.
  function automatic int select_width(input int nb_wragent);
    return (nb_wragent > 1) ? $clog2(nb_wragent) : 1;
  endfunction

  localparam int DEFAULT_NB_WRAGENT   = 2;
  localparam int DEFAULT_SELECT_WIDTH = select_width(DEFAULT_NB_WRAGENT);

  // Bank index for the default two-bank configuration.
  typedef logic [DEFAULT_SELECT_WIDTH-1:0] bank_idx_t;

endpackage

// File: rtl/bank_accounter_if.sv
// Write/read agent bus of the live-value table.
// The master side (write/read agents) drives enables and addresses; the
// slave side (bank_accounter) returns rdselect combinationally in the same
// cycle as rden/rdaddr, plus the registered wrcollision flag. There is no
// back-pressure: every enabled request is accepted in the cycle it is shown.
interface bank_accounter_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = meduram_pkg::select_width(NB_WRAGENT)
);

  logic [NB_WRAGENT-1:0]              wren;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr;
  logic [NB_RDAGENT-1:0]              rden;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect;
  logic                               wrcollision;

  modport master (
    output wren, wraddr, rden, rdaddr,
    input  rdselect, wrcollision
  );

  modport slave (
    input  wren, wraddr, rden, rdaddr,
    output rdselect, wrcollision
  );

endinterface

// File: rtl/bank_accounter_prio.sv
// Highest-index-wins encoder: given a hit vector, reports whether any bit is
// set and the index of the highest set bit. Shared by the per-entry write
// logic and by the write-to-read bypass path.
module bank_accounter_prio #(
  parameter int NB_WRAGENT   = 2,
  parameter int SELECT_WIDTH = meduram_pkg::select_width(NB_WRAGENT)
) (
  input  logic [NB_WRAGENT-1:0]   hit_i,
  output logic                    hit_o,
  output logic [SELECT_WIDTH-1:0] idx_o
);

  // Ascending scan so the last (highest) hit overwrites lower ones.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      if (hit_i[i]) begin
        hit_o = 1'b1;
        idx_o = SELECT_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/bank_accounter.sv
// Live-value table for the multi-port RAM: remembers, per address, which
// write bank last wrote it and hands that bank index to each read agent.
// Optional feature macro: BANK_ACCOUNTER_BYPASS_EN
//   defined   -> write-first: a read of an address written in the same cycle
//                returns the winning write index.
//   undefined -> read-first: such a read returns the pre-write table value.
module bank_accounter
  import meduram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = select_width(NB_WRAGENT)
) (
  input  logic            aclk,
  input  logic            aresetn,
  bank_accounter_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [SELECT_WIDTH-1:0] tbl_q   [DEPTH];
  logic [SELECT_WIDTH-1:0] tbl_d   [DEPTH];
  logic [DEPTH-1:0]        win_any;
  logic [SELECT_WIDTH-1:0] win_idx [DEPTH];
  logic                    wrcollision_q;
  logic                    wrcollision_d;

  // Per-entry write decode: which agents target this address, and who wins.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [NB_WRAGENT-1:0] wr_hit;

    // Hit vector for this entry across all write agents.
    always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NB_WRAGENT; i++) begin
        wr_hit[i] = bus.wren[i] &&
                    (bus.wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == ADDR_WIDTH'(e));
      end
    end

    bank_accounter_prio #(
      .NB_WRAGENT  (NB_WRAGENT),
      .SELECT_WIDTH(SELECT_WIDTH)
    ) u_wr_prio (
      .hit_i(wr_hit),
      .hit_o(win_any[e]),
      .idx_o(win_idx[e])
    );
  end

  // Next table contents: entries with a winning writer take its index.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      tbl_d[e] = win_any[e] ? win_idx[e] : tbl_q[e];
    end
  end

  // Table storage; reset makes every address resolve to bank 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int e = 0; e < DEPTH; e++) begin
        tbl_q[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        tbl_q[e] <= tbl_d[e];
      end
    end
  end

  // Read ports: combinational lookup, forced to 0 when the agent is idle.
  for (genvar j = 0; j < NB_RDAGENT; j++) begin : g_rd
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [SELECT_WIDTH-1:0] rd_val;

    assign rd_addr = bus.rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH];

`ifdef BANK_ACCOUNTER_BYPASS_EN
    logic [NB_WRAGENT-1:0]   byp_hit;
    logic                    byp_any;
    logic [SELECT_WIDTH-1:0] byp_idx;

    // Same-cycle writes to the read address; ignored while in reset since
    // those writes will never land in the table.
    always_comb begin
      byp_hit = '0;
      for (int i = 0; i < NB_WRAGENT; i++) begin
        byp_hit[i] = aresetn && bus.wren[i] &&
                     (bus.wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == rd_addr);
      end
    end

    bank_accounter_prio #(
      .NB_WRAGENT  (NB_WRAGENT),
      .SELECT_WIDTH(SELECT_WIDTH)
    ) u_byp_prio (
      .hit_i(byp_hit),
      .hit_o(byp_any),
      .idx_o(byp_idx)
    );

    assign rd_val = byp_any ? byp_idx : tbl_q[rd_addr];
`else
    assign rd_val = tbl_q[rd_addr];
`endif

    assign bus.rdselect[SELECT_WIDTH*j +: SELECT_WIDTH] = bus.rden[j] ? rd_val : '0;
  end

  // Collision detect: any two enabled write agents on the same address.
  always_comb begin
    wrcollision_d = 1'b0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      for (int k = i + 1; k < NB_WRAGENT; k++) begin
        if (bus.wren[i] && bus.wren[k] &&
            (bus.wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] ==
             bus.wraddr[ADDR_WIDTH*k +: ADDR_WIDTH])) begin
          wrcollision_d = 1'b1;
        end
      end
    end
  end

  // Registered one-cycle collision flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wrcollision_q <= 1'b0;
    end else begin
      wrcollision_q <= wrcollision_d;
    end
  end

  assign bus.wrcollision = wrcollision_q;

endmodule

// File: tb/tb_bank_accounter.sv
// Testbench for bank_accounter: directed scenarios with hand-computed
// expectations, then random traffic against a reference table model.
// Build with or without BANK_ACCOUNTER_BYPASS_EN; expectations follow.
module tb_bank_accounter;
  import meduram_pkg::*;

  localparam int AW = 8;
  localparam int NW = 2;
  localparam int NR = 2;
  localparam int SW = select_width(NW);
  localparam int EW = NR*SW + 1;

`ifdef BANK_ACCOUNTER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  bank_accounter_if #(
    .ADDR_WIDTH(AW), .NB_WRAGENT(NW), .NB_RDAGENT(NR), .SELECT_WIDTH(SW)
  ) bus ();

  bank_accounter #(
    .ADDR_WIDTH(AW), .NB_WRAGENT(NW), .NB_RDAGENT(NR), .SELECT_WIDTH(SW)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            checks = 0;
  int            errors = 0;

  bank_idx_t mdl [2**AW];
  logic      prev_coll;

  // ---------------- driver ----------------
  // Applies one cycle of requests just after the rising edge and queues the
  // expected {wrcollision, rdselect} for that cycle.
  task automatic drive(input logic          rst_n,
                       input logic [NW-1:0]    we,
                       input logic [NW*AW-1:0] wa,
                       input logic [NR-1:0]    re,
                       input logic [NR*AW-1:0] ra,
                       input logic             exp_coll,
                       input logic [NR*SW-1:0] exp_sel,
                       input string            tag);
    @(posedge aclk);
    #1;
    aresetn    = rst_n;
    bus.wren   = we;
    bus.wraddr = wa;
    bus.rden   = re;
    bus.rdaddr = ra;
    exp_q.push_back({exp_coll, exp_sel});
    tag_q.push_back(tag);
  endtask

  // ---------------- monitor ----------------
  // Compares DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge aclk) begin : mon
    logic [EW-1:0] e;
    string         t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (bus.rdselect !== e[NR*SW-1:0]) begin
        errors++;
        $display("FAIL %s rdselect: got %b expected %b", t, bus.rdselect, e[NR*SW-1:0]);
      end
      checks++;
      if (bus.wrcollision !== e[EW-1]) begin
        errors++;
        $display("FAIL %s wrcollision: got %b expected %b", t, bus.wrcollision, e[EW-1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    aresetn    = 1'b0;
    bus.wren   = '0;
    bus.wraddr = '0;
    bus.rden   = '0;
    bus.rdaddr = '0;
    repeat (2) @(posedge aclk);

    // Directed vectors: wraddr/rdaddr written as {agent1, agent0}.
    drive(1'b0, 2'b00, {8'h00, 8'h00}, 2'b11, {8'hFF, 8'h10}, 1'b0, 2'b00, "reset_read");
    drive(1'b1, 2'b00, {8'h00, 8'h00}, 2'b11, {8'hFF, 8'h10}, 1'b0, 2'b00, "unwritten");
    drive(1'b1, 2'b11, {8'h20, 8'h21}, 2'b00, {8'h00, 8'h00}, 1'b0, 2'b00, "split_write");
    drive(1'b1, 2'b00, {8'h00, 8'h00}, 2'b11, {8'h21, 8'h20}, 1'b0, 2'b01, "split_read");
    drive(1'b1, 2'b11, {8'h30, 8'h30}, 2'b00, {8'h00, 8'h00}, 1'b0, 2'b00, "coll_write");
    drive(1'b1, 2'b00, {8'h00, 8'h00}, 2'b00, {8'h00, 8'h00}, 1'b1, 2'b00, "coll_pulse");
    drive(1'b1, 2'b00, {8'h00, 8'h00}, 2'b01, {8'h00, 8'h30}, 1'b0, 2'b01, "coll_winner");
    drive(1'b1, 2'b10, {8'h40, 8'h00}, 2'b01, {8'h00, 8'h40}, 1'b0,
          BYPASS ? 2'b01 : 2'b00, "same_cycle_rw");
    drive(1'b1, 2'b00, {8'h00, 8'h00}, 2'b11, {8'h40, 8'h40}, 1'b0, 2'b11, "after_write");
    drive(1'b1, 2'b10, {8'h50, 8'h00}, 2'b00, {8'h00, 8'h00}, 1'b0, 2'b00, "seed_50");
    drive(1'b1, 2'b11, {8'h70, 8'h70}, 2'b10, {8'h50, 8'h50}, 1'b0, 2'b10, "rden_gate");
    drive(1'b0, 2'b00, {8'h00, 8'h00}, 2'b11, {8'h50, 8'h50}, 1'b0, 2'b00, "mid_reset");
    drive(1'b1, 2'b00, {8'h00, 8'h00}, 2'b11, {8'h50, 8'h70}, 1'b0, 2'b00, "post_reset");
    drive(1'b1, 2'b11, {8'h60, 8'h60}, 2'b01, {8'h00, 8'h60}, 1'b0,
          BYPASS ? 2'b01 : 2'b00, "bypass_coll");
    drive(1'b1, 2'b00, {8'h00, 8'h00}, 2'b11, {8'h60, 8'h60}, 1'b1, 2'b11, "coll_after");
    drive(1'b1, 2'b00, {8'h00, 8'h00}, 2'b10, {8'h61, 8'h60}, 1'b0, 2'b00, "unwritten_61");

    // Random traffic against the reference table, starting from reset.
    drive(1'b0, 2'b00, {8'h00, 8'h00}, 2'b11, {8'h07, 8'h03}, 1'b0, 2'b00, "rand_reset");
    for (int e = 0; e < 2**AW; e++) mdl[e] = '0;
    prev_coll = 1'b0;

    for (int n = 0; n < 10000; n++) begin
      logic [NW-1:0]    we;
      logic [NW*AW-1:0] wa;
      logic [NR-1:0]    re;
      logic [NR*AW-1:0] ra;
      logic [NR*SW-1:0] es;
      logic             coll_n;
      logic [AW-1:0]    a;
      bank_idx_t        v;

      we = NW'($urandom_range(0, (1 << NW) - 1));
      re = NR'($urandom_range(0, (1 << NR) - 1));
      for (int i = 0; i < NW; i++) wa[i*AW +: AW] = AW'($urandom_range(0, 7));
      for (int j = 0; j < NR; j++) ra[j*AW +: AW] = AW'($urandom_range(0, 7));

      es = '0;
      for (int j = 0; j < NR; j++) begin
        a = ra[j*AW +: AW];
        v = '0;
        if (re[j]) begin
          v = mdl[a];
          if (BYPASS) begin
            for (int i = 0; i < NW; i++)
              if (we[i] && wa[i*AW +: AW] == a) v = bank_idx_t'(i);
          end
        end
        es[j*SW +: SW] = v;
      end

      coll_n = 1'b0;
      for (int i = 0; i < NW; i++)
        for (int k = i + 1; k < NW; k++)
          if (we[i] && we[k] && wa[i*AW +: AW] == wa[k*AW +: AW]) coll_n = 1'b1;

      drive(1'b1, we, wa, re, ra, prev_coll, es, "rand");

      for (int i = 0; i < NW; i++)
        if (we[i]) mdl[wa[i*AW +: AW]] = bank_idx_t'(i);
      prev_coll = coll_n;
    end

    // Let the monitor drain, bounded.
    repeat (3) @(negedge aclk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
